// File: rtl/dac_spi_tx_if.sv
// Sample-stream handshake and DAC pin bundle for dac_spi_tx.
// The master drives the sample side and the slave (dac_spi_tx) drives the DAC pins and status.
interface dac_spi_tx_if;
  logic [15:0] SAMPLE;
  logic        SAMPLE_VALID;
  logic        SAMPLE_ACK;
  logic        CLR_FLAGS;
  logic        DAC_SCLK;
  logic        DAC_SYNC_N;
  logic        DAC_DIN;
  logic        BUSY;
  logic        UNDERRUN;
  logic        OVERRUN;

  modport master (
    output SAMPLE, SAMPLE_VALID, CLR_FLAGS,
    input  SAMPLE_ACK, DAC_SCLK, DAC_SYNC_N, DAC_DIN, BUSY, UNDERRUN, OVERRUN
  );

  modport slave (
    input  SAMPLE, SAMPLE_VALID, CLR_FLAGS,
    output SAMPLE_ACK, DAC_SCLK, DAC_SYNC_N, DAC_DIN, BUSY, UNDERRUN, OVERRUN
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Sample-rate timebase and 24-bit SPI serialiser for a DAC8551-class DAC.
// Define DAC_TX_LOCK_EN to add the LOCKED input that freezes the sample-rate counter.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned SAMPLE_DIV = 2048
) (
  input  logic CLK,
  input  logic RST,
`ifdef DAC_TX_LOCK_EN
  input  logic LOCKED,
`endif
  dac_spi_tx_if.slave bus
);

  localparam int unsigned HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(SAMPLE_DIV - 1);
  localparam logic [4:0]    BIT_MSB   = 5'd23;
  localparam logic [15:0]   MIDSCALE  = 16'h8000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_half;
  logic [HW-1:0] w_half_nxt;
  logic [4:0]    r_bit;
  logic [4:0]    w_bit_nxt;
  logic          r_phase_hi;
  logic          w_phase_hi_nxt;
  logic [RW-1:0] r_rate;
  logic [15:0]   r_held;
  logic [15:0]   w_held_nxt;
  logic [23:0]   w_frame_nxt;

  logic w_run;
  logic w_tick;
  logic w_tick_idle;
  logic w_accept;
  logic w_set_under;
  logic w_set_over;
  logic w_half_done;
  logic w_sclk_nxt;
  logic w_sync_n_nxt;
  logic w_din_nxt;

  logic r_sclk;
  logic r_sync_n;
  logic r_din;
  logic r_busy;
  logic r_ack;
  logic r_under;
  logic r_over;

`ifdef DAC_TX_LOCK_EN
  assign w_run = LOCKED;
`else
  assign w_run = 1'b1;
`endif

  assign w_tick      = w_run && (r_rate == RATE_LAST);
  assign w_tick_idle = w_tick && (r_state == S_IDLE);
  assign w_accept    = w_tick_idle && bus.SAMPLE_VALID;
  assign w_set_under = w_tick_idle && !bus.SAMPLE_VALID;
  assign w_set_over  = w_tick && (r_state != S_IDLE);
  assign w_half_done = (r_half == HALF_LAST);
  assign w_held_nxt  = w_accept ? bus.SAMPLE : r_held;
  assign w_frame_nxt = {6'b0, 2'b00, w_held_nxt};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rate <= '0;
    end else if (w_run) begin
      r_rate <= (r_rate == RATE_LAST) ? '0 : r_rate + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_half     <= '0;
      r_bit      <= '0;
      r_phase_hi <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_half     <= w_half_nxt;
      r_bit      <= w_bit_nxt;
      r_phase_hi <= w_phase_hi_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_half_nxt     = r_half;
    w_bit_nxt      = r_bit;
    w_phase_hi_nxt = r_phase_hi;
    unique case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_SETUP;
          w_half_nxt  = '0;
          w_bit_nxt   = BIT_MSB;
        end
      end
      S_SETUP: begin
        if (w_half_done) begin
          w_state_nxt    = S_SHIFT;
          w_half_nxt     = '0;
          w_bit_nxt      = BIT_MSB;
          w_phase_hi_nxt = 1'b1;
        end else begin
          w_half_nxt = r_half + 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_half_done) begin
          w_half_nxt = '0;
          if (r_phase_hi) begin
            w_phase_hi_nxt = 1'b0;
          end else if (r_bit == '0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_bit_nxt      = r_bit - 1'b1;
            w_phase_hi_nxt = 1'b1;
          end
        end else begin
          w_half_nxt = r_half + 1'b1;
        end
      end
      S_GAP: begin
        if (w_half_done) begin
          w_state_nxt = S_IDLE;
          w_half_nxt  = '0;
        end else begin
          w_half_nxt = r_half + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Pin values are decoded from the next state so the output flops line up with the state flop.
    w_sync_n_nxt = !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
    w_sclk_nxt   = (w_state_nxt == S_SHIFT) && w_phase_hi_nxt;
    w_din_nxt    = !w_sync_n_nxt && w_frame_nxt[w_bit_nxt];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_held   <= MIDSCALE;
      r_sclk   <= 1'b0;
      r_sync_n <= 1'b1;
      r_din    <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_under  <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_held   <= w_held_nxt;
      r_sclk   <= w_sclk_nxt;
      r_sync_n <= w_sync_n_nxt;
      r_din    <= w_din_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_ack    <= w_accept;
      if (w_set_under) begin
        r_under <= 1'b1;
      end else if (bus.CLR_FLAGS) begin
        r_under <= 1'b0;
      end
      if (w_set_over) begin
        r_over <= 1'b1;
      end else if (bus.CLR_FLAGS) begin
        r_over <= 1'b0;
      end
    end
  end

  assign bus.SAMPLE_ACK = r_ack;
  assign bus.DAC_SCLK   = r_sclk;
  assign bus.DAC_SYNC_N = r_sync_n;
  assign bus.DAC_DIN    = r_din;
  assign bus.BUSY       = r_busy;
  assign bus.UNDERRUN   = r_under;
  assign bus.OVERRUN    = r_over;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: two instances (sample period 128 and 64 clocks) against a timeline model.
// The model predicts every pin from cycles elapsed since frame start; a decoder also rebuilds each SPI frame.
module tb_dac_spi_tx;

  localparam int CD     = 2;
  localparam int SDIV_A = 128;
  localparam int SDIV_B = 64;
  localparam int SYNC_LOW = 49 * CD;
  localparam int BUSY_LEN = 50 * CD;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic lock_a = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  dac_spi_tx_if a_if ();
  dac_spi_tx_if b_if ();

  dac_spi_tx #(.CLK_DIV(CD), .SAMPLE_DIV(SDIV_A)) u_dut_a (
    .CLK    (CLK),
    .RST    (RST),
`ifdef DAC_TX_LOCK_EN
    .LOCKED (lock_a),
`endif
    .bus    (a_if.slave)
  );

  dac_spi_tx #(.CLK_DIV(CD), .SAMPLE_DIV(SDIV_B)) u_dut_b (
    .CLK    (CLK),
    .RST    (RST),
`ifdef DAC_TX_LOCK_EN
    .LOCKED (1'b1),
`endif
    .bus    (b_if.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Timeline model state, index 0 = instance A, 1 = instance B.
  logic        known[2]     = '{1'b0, 1'b0};
  int          rcnt[2];
  int          age[2];
  logic [15:0] held[2];
  logic        e_ack[2];
  logic        e_un[2];
  logic        e_ov[2];
  logic        prev_sclk[2] = '{1'b0, 1'b0};
  logic        prev_sync[2] = '{1'b1, 1'b1};
  logic [23:0] dec[2];
  int          nb[2];
  int          lowlen[2];

  function automatic int sdiv(input int d);
    return (d == 0) ? SDIV_A : SDIV_B;
  endfunction

  task automatic model_step(input int d, input logic rst, input logic locked,
                            input logic valid, input logic [15:0] smp, input logic clr,
                            input logic ack, input logic sclk, input logic sync_n,
                            input logic din, input logic busy, input logic un, input logic ov);
    int a;
    int bi;
    logic e_sync, e_sclk, e_din, e_busy, tick, start, set_u, set_o;
    logic [23:0] fw;
    string p;
    p = (d == 0) ? "A" : "B";
    if (known[d]) begin
      a  = age[d];
      fw = {8'h00, held[d]};
      e_busy = (a >= 0);
      e_sync = !(a >= 0 && a < SYNC_LOW);
      e_sclk = (a >= CD) && (a < SYNC_LOW) && (((a - CD) % (2 * CD)) < CD);
      if (a >= 0 && a < CD) e_din = fw[23];
      else if (a >= CD && a < SYNC_LOW) begin
        bi = 23 - (a - CD) / (2 * CD);
        e_din = fw[bi];
      end else e_din = 1'b0;
      check_eq($sformatf("%s.ack", p),      32'(ack),    32'(e_ack[d]));
      check_eq($sformatf("%s.sclk", p),     32'(sclk),   32'(e_sclk));
      check_eq($sformatf("%s.sync_n", p),   32'(sync_n), 32'(e_sync));
      check_eq($sformatf("%s.din", p),      32'(din),    32'(e_din));
      check_eq($sformatf("%s.busy", p),     32'(busy),   32'(e_busy));
      check_eq($sformatf("%s.underrun", p), 32'(un),     32'(e_un[d]));
      check_eq($sformatf("%s.overrun", p),  32'(ov),     32'(e_ov[d]));

      // Frame decoder: DAC view of the pins.
      if (!sync_n && prev_sclk[d] && !sclk) begin
        dec[d] = {dec[d][22:0], din};
        nb[d]++;
      end
      if (!sync_n) lowlen[d]++;
      if (sync_n && !prev_sync[d]) begin
        check_eq($sformatf("%s.frame_word", p), 32'(dec[d]), 32'(fw));
        check_eq($sformatf("%s.frame_bits", p), 32'(nb[d]), 32'(24));
        check_eq($sformatf("%s.sync_low_len", p), 32'(lowlen[d]), 32'(SYNC_LOW));
      end
      if (sync_n) begin
        dec[d] = '0;
        nb[d] = 0;
        lowlen[d] = 0;
      end
      prev_sclk[d] = sclk;
      prev_sync[d] = sync_n;
    end

    if (rst) begin
      known[d] = 1'b1;
      rcnt[d] = 0;
      age[d] = -1;
      held[d] = 16'h8000;
      e_ack[d] = 1'b0;
      e_un[d] = 1'b0;
      e_ov[d] = 1'b0;
      prev_sclk[d] = 1'b0;
      prev_sync[d] = 1'b1;
      dec[d] = '0;
      nb[d] = 0;
      lowlen[d] = 0;
    end else if (known[d]) begin
      tick = locked && (rcnt[d] == sdiv(d) - 1);
      if (locked) rcnt[d] = tick ? 0 : rcnt[d] + 1;
      start = 1'b0;
      set_u = 1'b0;
      set_o = 1'b0;
      e_ack[d] = 1'b0;
      if (tick) begin
        if (age[d] < 0) begin
          start = 1'b1;
          if (valid) begin
            held[d] = smp;
            e_ack[d] = 1'b1;
          end else begin
            set_u = 1'b1;
          end
        end else begin
          set_o = 1'b1;
        end
      end
      e_un[d] = set_u | (e_un[d] & !clr);
      e_ov[d] = set_o | (e_ov[d] & !clr);
      if (start) age[d] = 0;
      else if (age[d] >= 0) age[d] = (age[d] == BUSY_LEN - 1) ? -1 : age[d] + 1;
    end
  endtask

  always @(negedge CLK) begin
    model_step(0, RST, lock_a, a_if.SAMPLE_VALID, a_if.SAMPLE, a_if.CLR_FLAGS,
               a_if.SAMPLE_ACK, a_if.DAC_SCLK, a_if.DAC_SYNC_N, a_if.DAC_DIN,
               a_if.BUSY, a_if.UNDERRUN, a_if.OVERRUN);
    model_step(1, RST, 1'b1, b_if.SAMPLE_VALID, b_if.SAMPLE, b_if.CLR_FLAGS,
               b_if.SAMPLE_ACK, b_if.DAC_SCLK, b_if.DAC_SYNC_N, b_if.DAC_DIN,
               b_if.BUSY, b_if.UNDERRUN, b_if.OVERRUN);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack_a(input int budget);
    int k;
    k = 0;
    while (a_if.SAMPLE_ACK !== 1'b1 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check_eq("A.ack_within_budget", 32'(a_if.SAMPLE_ACK === 1'b1), 32'd1);
    cyc(1);
  endtask

  task automatic wait_sync_fall_a(input int budget);
    int k;
    k = 0;
    @(negedge CLK);
    while (a_if.DAC_SYNC_N !== 1'b0 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    check_eq("A.sync_fall_within_budget", 32'(a_if.DAC_SYNC_N === 1'b0), 32'd1);
  endtask

  task automatic pulse_clr_a();
    a_if.CLR_FLAGS = 1'b1;
    cyc(1);
    a_if.CLR_FLAGS = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_if.SAMPLE = 16'h0000;
    a_if.SAMPLE_VALID = 1'b0;
    a_if.CLR_FLAGS = 1'b0;
    b_if.SAMPLE = 16'h5A5A;
    b_if.SAMPLE_VALID = 1'b1;
    b_if.CLR_FLAGS = 1'b0;

    // Reset, then first frame with no valid sample: midscale repeats and UNDERRUN sets.
    cyc(3);
    RST = 1'b0;
    cyc(SDIV_A + BUSY_LEN + 10);
    check_eq("A.underrun_after_first_tick", 32'(a_if.UNDERRUN), 32'd1);

    // Single sample after clearing flags.
    pulse_clr_a();
    a_if.SAMPLE = 16'hA5C3;
    a_if.SAMPLE_VALID = 1'b1;
    wait_ack_a(SDIV_A + 4);
    a_if.SAMPLE_VALID = 1'b0;
    a_if.SAMPLE = 16'h0000;
    cyc(BUSY_LEN);
    check_eq("A.underrun_after_valid_frame", 32'(a_if.UNDERRUN), 32'd0);

    // Hold then underrun: second frame repeats 0x1234.
    a_if.SAMPLE = 16'h1234;
    a_if.SAMPLE_VALID = 1'b1;
    wait_ack_a(SDIV_A + 4);
    a_if.SAMPLE_VALID = 1'b0;
    a_if.SAMPLE = 16'hFFFF;
    cyc(SDIV_A + BUSY_LEN);
    check_eq("A.underrun_on_hold", 32'(a_if.UNDERRUN), 32'd1);
    pulse_clr_a();
    cyc(1);
    check_eq("A.underrun_cleared", 32'(a_if.UNDERRUN), 32'd0);

    // Reset mid-frame after bit 13 (11 bits shifted), then a clean frame.
    a_if.SAMPLE = 16'h3C69;
    a_if.SAMPLE_VALID = 1'b1;
    wait_sync_fall_a(SDIV_A + 4);
    repeat (CD + 11 * 2 * CD) @(posedge CLK);
    #1;
    RST = 1'b1;
    cyc(1);
    RST = 1'b0;
    check_eq("A.sync_n_after_mid_reset", 32'(a_if.DAC_SYNC_N), 32'd1);
    check_eq("A.busy_after_mid_reset", 32'(a_if.BUSY), 32'd0);
    a_if.SAMPLE = 16'hC0DE;
    cyc(SDIV_A + BUSY_LEN + 10);

    // Randomized traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      a_if.SAMPLE = 16'($urandom);
      a_if.SAMPLE_VALID = ($urandom_range(3) != 0);
      a_if.CLR_FLAGS = ($urandom_range(31) == 0);
      b_if.SAMPLE = 16'($urandom);
      b_if.SAMPLE_VALID = ($urandom_range(3) != 0);
      b_if.CLR_FLAGS = ($urandom_range(31) == 0);
      cyc(1);
    end
    a_if.CLR_FLAGS = 1'b0;
    b_if.CLR_FLAGS = 1'b0;

`ifdef DAC_TX_LOCK_EN
    // Counter frozen while unlocked: no frames, no flags.
    a_if.SAMPLE_VALID = 1'b0;
    cyc(BUSY_LEN + 4);
    pulse_clr_a();
    lock_a = 1'b0;
    cyc(500);
    check_eq("A.no_underrun_while_unlocked", 32'(a_if.UNDERRUN), 32'd0);
    lock_a = 1'b1;
    a_if.SAMPLE = 16'h7E81;
    a_if.SAMPLE_VALID = 1'b1;
    wait_sync_fall_a(SDIV_A + 4);
    cyc(20);
    lock_a = 1'b0;
    cyc(BUSY_LEN + 20);
    lock_a = 1'b1;
    cyc(SDIV_A);
`endif

    cyc(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
